// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the memory arbiter state encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction-fetch and data-access ports.
// Data requests win in IDLE; an in-flight access is never preempted, but it
// is abandoned at once if its requester withdraws, and it is forced to
// complete with an error after TIMEOUT in-flight cycles without ram_ready.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic  CLK,
  input  logic  RST,
  // instruction-fetch port
  input  logic  iREN,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  // data-access port
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  // shared RAM
  output logic  ram_ren,
  output logic  ram_wen,
  output word_t ram_addr,
  output word_t ram_store,
  input  logic  ram_ready,
  input  word_t ram_load,
  // sticky error
  output logic  err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic             d_req;
  logic             timeout_hit;
  logic             timeout_err;

  assign d_req       = dREN | dWEN;
  assign timeout_hit = (cnt == CNT_LAST);

  // State register; reset abandons any in-flight access and drops strobes.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // In-flight cycle counter: held at zero in IDLE, so it is zero in the first
  // cycle of every access (accesses are only entered from IDLE).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else                    cnt <= cnt + CNT_W'(1);
  end

  // Sticky error: timeout, or a data request with both strobes raised.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                     err <= 1'b0;
    else if (timeout_err || (dREN && dWEN))      err <= 1'b1;
  end

  // Next-state and output decode; strobes and completions follow the
  // requester combinationally so a withdrawal cancels in the same cycle.
  // NOTE: every output gets a default first so no path through the case can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    timeout_err = 1'b0;
    iwait       = 1'b1;
    iload       = '0;
    dwait       = 1'b1;
    dload       = '0;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_store   = '0;

    unique case (state)
      IDLE: begin
        if (d_req)     state_next = DACC;
        else if (iREN) state_next = IACC;
      end

      IACC: begin
        if (!iREN) begin
          // Flush: drop the strobe now, ignore any ram_ready this cycle.
          state_next = IDLE;
        end else begin
          ram_ren  = 1'b1;
          ram_addr = iaddr;
          if (ram_ready) begin
            iwait      = 1'b0;
            iload      = ram_load;
            state_next = IDLE;
          end else if (timeout_hit) begin
            iwait       = 1'b0;
            timeout_err = 1'b1;
            state_next  = IDLE;
          end
        end
      end

      DACC: begin
        if (!d_req) begin
          state_next = IDLE;
        end else begin
          ram_addr = daddr;
          // A write wins when both strobes are raised.
          if (dWEN) begin
            ram_wen   = 1'b1;
            ram_store = dstore;
          end else begin
            ram_ren = 1'b1;
          end
          if (ram_ready) begin
            dwait      = 1'b0;
            dload      = ram_load;
            state_next = IDLE;
          end else if (timeout_hit) begin
            dwait       = 1'b0;
            timeout_err = 1'b1;
            state_next  = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (built with TIMEOUT=8).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  iREN, dREN, dWEN, ram_ready;
  word_t iaddr, daddr, dstore, ram_load;
  logic  iwait, dwait, ram_ren, ram_wen, err;
  word_t iload, dload, ram_addr, ram_store;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ram_ren  (ram_ren),
    .ram_wen  (ram_wen),
    .ram_addr (ram_addr),
    .ram_store(ram_store),
    .ram_ready(ram_ready),
    .ram_load (ram_load),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then let new inputs settle after it.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ren"},   32'(ram_ren),  32'd0);
    check({tag, ".wen"},   32'(ram_wen),  32'd0);
    check({tag, ".addr"},  ram_addr,      32'd0);
    check({tag, ".store"}, ram_store,     32'd0);
    check({tag, ".iwait"}, 32'(iwait),    32'd1);
    check({tag, ".dwait"}, 32'(dwait),    32'd1);
    check({tag, ".iload"}, iload,         32'd0);
    check({tag, ".dload"}, dload,         32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;
    #12;
    check_idle_outputs("reset");
    check("reset.err", 32'(err), 32'd0);
    cyc(); rst = 1'b0;

    // ---------------- read only, ready on 3rd strobe cycle ----------------
    cyc(); iREN = 1; iaddr = 32'h40; settle();
    check("rd.idle_ren", 32'(ram_ren), 32'd0);
    for (int k = 1; k <= 2; k++) begin
      cyc(); settle();
      check($sformatf("rd.ren%0d", k),  32'(ram_ren), 32'd1);
      check($sformatf("rd.addr%0d", k), ram_addr,     32'h40);
      check($sformatf("rd.iwait%0d", k), 32'(iwait),  32'd1);
    end
    cyc(); ram_ready = 1; ram_load = 32'h8C220004; settle();
    check("rd.ren3",  32'(ram_ren), 32'd1);
    check("rd.iwait", 32'(iwait),   32'd0);
    check("rd.iload", iload,        32'h8C220004);
    cyc(); iREN = 0; ram_ready = 0; settle();
    check("rd.after_ren",   32'(ram_ren), 32'd0);
    check("rd.after_iwait", 32'(iwait),   32'd1);

    // ---------------- contention: data write wins ----------------
    cyc(); iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; settle();
    check("ct.idle_wen", 32'(ram_wen), 32'd0);
    cyc(); settle();
    check("ct.wen",   32'(ram_wen), 32'd1);
    check("ct.ren",   32'(ram_ren), 32'd0);
    check("ct.addr",  ram_addr,     32'h100);
    check("ct.store", ram_store,    32'hDEADBEEF);
    cyc(); ram_ready = 1; ram_load = 32'h0; settle();
    check("ct.dwait", 32'(dwait), 32'd0);
    check("ct.iwait", 32'(iwait), 32'd1);
    check("ct.ren2",  32'(ram_ren), 32'd0);
    cyc(); dWEN = 0; ram_ready = 0; settle();
    check("ct.gap_ren", 32'(ram_ren), 32'd0);
    check("ct.gap_wen", 32'(ram_wen), 32'd0);
    cyc(); settle();
    check("ct.iacc_ren",  32'(ram_ren), 32'd1);
    check("ct.iacc_wen",  32'(ram_wen), 32'd0);
    check("ct.iacc_addr", ram_addr,     32'h44);
    cyc(); ram_ready = 1; ram_load = 32'h11112222; settle();
    check("ct.iwait", 32'(iwait), 32'd0);
    check("ct.iload", iload,      32'h11112222);
    cyc(); iREN = 0; ram_ready = 0;

    // ---------------- no preemption ----------------
    cyc(); iREN = 1; iaddr = 32'h48;
    cyc(); dREN = 1; daddr = 32'h200; settle();
    check("np.ren",   32'(ram_ren), 32'd1);
    check("np.addr",  ram_addr,     32'h48);
    check("np.dwait", 32'(dwait),   32'd1);
    cyc(); ram_ready = 1; ram_load = 32'hAAAA0001; settle();
    check("np.iwait",  32'(iwait), 32'd0);
    check("np.iload",  iload,      32'hAAAA0001);
    check("np.dwait2", 32'(dwait), 32'd1);
    cyc(); iREN = 0; ram_ready = 0; settle();
    check("np.gap_ren", 32'(ram_ren), 32'd0);
    cyc(); settle();
    check("np.dacc_ren",  32'(ram_ren), 32'd1);
    check("np.dacc_addr", ram_addr,     32'h200);
    cyc(); ram_ready = 1; ram_load = 32'h5555AAAA; settle();
    check("np.dwait3", 32'(dwait), 32'd0);
    check("np.dload",  dload,      32'h5555AAAA);
    cyc(); dREN = 0; ram_ready = 0;

    // ---------------- withdrawal ----------------
    cyc(); iREN = 1; iaddr = 32'h4C;
    cyc(); settle();
    check("wd.ren1", 32'(ram_ren), 32'd1);
    cyc(); settle();
    check("wd.ren2", 32'(ram_ren), 32'd1);
    cyc(); iREN = 0; ram_ready = 1; ram_load = 32'h12345678; settle();
    check("wd.ren_drop", 32'(ram_ren), 32'd0);
    check("wd.iload",    iload,        32'd0);
    cyc(); settle();
    check("wd.late_ren",   32'(ram_ren), 32'd0);
    check("wd.late_iwait", 32'(iwait),   32'd1);
    check("wd.late_dwait", 32'(dwait),   32'd1);
    cyc(); ram_ready = 0; settle();
    check("wd.err", 32'(err), 32'd0);

    // ---------------- timeout (TIMEOUT=8) ----------------
    cyc(); dREN = 1; daddr = 32'h300; ram_load = 32'hFFFFFFFF;
    for (int k = 1; k <= 7; k++) begin
      cyc(); settle();
      check($sformatf("to.ren%0d", k),   32'(ram_ren), 32'd1);
      check($sformatf("to.dwait%0d", k), 32'(dwait),   32'd1);
    end
    cyc(); settle();
    check("to.dwait8", 32'(dwait), 32'd0);
    check("to.dload8", dload,      32'd0);
    cyc(); dREN = 0; settle();
    check("to.err",      32'(err),     32'd1);
    check("to.idle_ren", 32'(ram_ren), 32'd0);
    cyc(); cyc(); settle();
    check("to.err_sticky", 32'(err), 32'd1);

    // ---------------- async reset mid-DACC ----------------
    cyc(); dWEN = 1; daddr = 32'h400; dstore = 32'hCAFEF00D;
    cyc(); settle();
    check("ar.wen", 32'(ram_wen), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar.wen_drop", 32'(ram_wen), 32'd0);
    check("ar.err_clr",  32'(err),     32'd0);
    dWEN = 0;
    cyc(); rst = 1'b0; settle();
    check_idle_outputs("ar.post");
    cyc(); iREN = 1; iaddr = 32'h50;
    cyc(); settle();
    check("ar.ren",  32'(ram_ren), 32'd1);
    check("ar.addr", ram_addr,     32'h50);
    cyc(); ram_ready = 1; ram_load = 32'h0BADCAFE; settle();
    check("ar.iwait", 32'(iwait), 32'd0);
    check("ar.iload", iload,      32'h0BADCAFE);
    cyc(); iREN = 0; ram_ready = 0; settle();
    check("ar.err", 32'(err), 32'd0);

    // ---------------- dREN and dWEN together: write plus error ----------------
    cyc(); dREN = 1; dWEN = 1; daddr = 32'h500; dstore = 32'h00C0FFEE;
    cyc(); settle();
    check("bw.wen",   32'(ram_wen), 32'd1);
    check("bw.ren",   32'(ram_ren), 32'd0);
    check("bw.store", ram_store,    32'h00C0FFEE);
    check("bw.err",   32'(err),     32'd1);
    cyc(); ram_ready = 1; ram_load = '0; settle();
    check("bw.dwait", 32'(dwait), 32'd0);
    cyc(); dREN = 0; dWEN = 0; ram_ready = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the pipeline's instruction-fetch and data-access request ports and one shared word-addressed RAM. It sits at the far end of the hit/wait handshake that gates the pipeline latches: it serializes instruction and data requests onto the RAM, returns load data, and drops the matching wait line for exactly the cycle the access completes. Data accesses have priority over instruction fetches, and an in-flight access is never preempted.

## Interface
- TIMEOUT, default 64: maximum cycles an access may stay in flight before it is forced to complete with an error.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- iREN  in  1  instruction read request; held until iwait is seen low.
- iaddr  in  32  instruction word address.
- iwait  out  1  high while an instruction request is pending or not yet completed.
- iload  out  32  instruction data; valid only when iREN=1 and iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  high while a data request is pending or not yet completed.
- dload  out  32  read data; valid only when dREN=1 and dwait=0.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  32  RAM address.
- ram_store  out  32  RAM write data.
- ram_ready  in  1  RAM completion pulse; one cycle per access.
- ram_load  in  32  RAM read data; valid with ram_ready.
- err  out  1  sticky error: timeout or dREN and dWEN both high.

## Operation
- FSM states: IDLE, IACC, DACC.
- IDLE: if dREN|dWEN, go to DACC. Otherwise, if iREN, go to IACC. Otherwise stay. Decision is made on the edge.
- IACC: ram_ren=1, ram_addr=iaddr. On ram_ready: iwait=0 and iload=ram_load combinationally in that cycle, then go to IDLE.
- DACC: ram_addr=daddr. If dWEN, ram_wen=1 and ram_store=dstore; otherwise ram_ren=1. On ram_ready: dwait=0, dload=ram_load, then go to IDLE.
- iwait=1 whenever iREN=1, except during the IACC completion cycle. dwait behaves the same way for dREN|dWEN in DACC. When no request is present, the wait line is 1 (don't-care to requester).
- Withdrawal: if the owning request drops mid-access (pipeline flush), the strobes deassert in that same cycle and the FSM goes to IDLE on the next edge. A ram_ready arriving in that cycle is ignored.
- dREN and dWEN both high: treat as a write and set err.
- Timeout: cycle counter cleared on entry to IACC/DACC, incremented each cycle in flight. When it reaches TIMEOUT-1 without ram_ready, force completion with wait=0 and load data 0, set err, and go to IDLE.
- Strobes are never both high; in IDLE all ram_* outputs are 0.

## Timing
- Reset values: FSM=IDLE, counter=0, err=0, ram_ren=ram_wen=0, ram_addr=ram_store=0, iload=dload=0, iwait=dwait=1.
- Minimum latency: request seen in IDLE at edge N; strobe asserted in cycle N+1. If ram_ready arrives in N+1, wait goes low in N+1 and the FSM is IDLE at N+2. This gives 2 cycles from request to completion edge.
- Back-to-back: a request still high in IDLE after completion is treated as a new access. Requesters must advance their address or drop the request on the completion edge.
- Simultaneous iREN and data request in IDLE: data wins. The instruction request waits one full data access plus one IDLE cycle.
- A data request arriving during IACC waits; no preemption.
- RST asserted mid-access: strobes drop immediately (asynchronous) and the in-flight access is abandoned.

## Structure
- cpu_types_pkg holds word_t (32-bit), and an arb_state_t enum {IDLE, IACC, DACC}.
- TIMEOUT stays a module parameter; the counter width is $clog2(TIMEOUT)+1.
- No sub-module. Implement as one FSM register, one counter, one sticky err flop, and combinational output decode.

## Test plan
- Read only: iREN=1, iaddr=0x40, RAM ready 3 cycles after strobe with 0x8C220004 -> ram_ren high for 3 cycles, then iwait=0 for exactly one cycle with iload=0x8C220004.
- Contention: iREN and dWEN high together, daddr=0x100, dstore=0xDEADBEEF -> write issued first (ram_wen, ram_store=0xDEADBEEF). Instruction read starts after one IDLE cycle; never both strobes high.
- No preemption: dREN rises 1 cycle into an IACC -> IACC completes, then DACC; dload matches ram_load of the second access.
- Withdrawal: iREN drops 2 cycles into IACC -> ram_ren=0 in that cycle, FSM is IDLE next cycle, a late ram_ready is ignored, err=0.
- Timeout with TIMEOUT=8 and RAM never ready -> completion in the 8th in-flight cycle with dload=0 and err=1; err stays high until RST.
- Asynchronous reset mid-DACC -> ram_wen=0 immediately; after release, all reset values hold and a new iREN is serviced normally.
